// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: access-size encodings, FSM states and the alignment rule shared by the load/store unit.
package mem_access_unit_pkg;
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  typedef enum logic [2:0] {IDLE, LD_ISSUE, LD_DATA, RMW_ISSUE, RMW_MERGE, ST_WRITE, RESP} state_t;
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    return (size == SIZE_H) ? a[0] : (size != SIZE_B) ? (a != 2'b00) : 1'b0;
  endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: little-endian lane extract/extend for loads and lane merge for sub-word stores.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_addr,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);
  logic [4:0]  w_sh;
  logic [31:0] w_mask;
  logic [15:0] w_lane;
  always_comb begin
    w_sh = (i_size == SIZE_B) ? {i_addr, 3'b000} : (i_size == SIZE_H) ? {i_addr[1], 4'b0000} : 5'd0;
    w_mask = ((i_size == SIZE_B) ? 32'h0000_00FF : (i_size == SIZE_H) ? 32'h0000_FFFF : 32'hFFFF_FFFF) << w_sh;
    w_lane = 16'(i_word >> w_sh);
    o_load = (i_size == SIZE_B) ? {{24{~i_unsigned & w_lane[7]}}, w_lane[7:0]} :
             (i_size == SIZE_H) ? {{16{~i_unsigned & w_lane[15]}}, w_lane} : i_word;
    o_merged = (i_word & ~w_mask) | ((i_wdata << w_sh) & w_mask);
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store initiator converting byte/half/word accesses into word transactions.
// Define MEM_ACCESS_MISALIGN_CHECK_EN to answer misaligned half/word accesses with resp_err_o instead of aligning them.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic          req_we_i,
  input  logic [1:0]    req_size_i,
  input  logic          req_unsigned_i,
  input  logic [AW-1:0] req_addr_i,
  input  logic [DW-1:0] req_wdata_i,
  output logic          resp_valid_o,
  output logic [DW-1:0] resp_rdata_o,
  output logic          resp_err_o,
  output logic          memread_o,
  output logic          memwrite_o,
  output logic [AW-1:0] memaddr_o,
  output logic [DW-1:0] memwdata_o,
  input  logic [DW-1:0] memrdata_i
);
  state_t        r_state;
  logic [1:0]    r_size, r_a;
  logic          r_uns;
  logic [DW-1:0] r_wdata, w_load, w_merged;
  assign req_ready_o = (r_state == IDLE);
  mem_lane_align u_lane (
    .i_word(memrdata_i), .i_wdata(r_wdata), .i_addr(r_a), .i_size(r_size),
    .i_unsigned(r_uns), .o_load(w_load), .o_merged(w_merged)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_size <= SIZE_B;
      r_a <= 2'b00;
      r_uns <= 1'b0;
      r_wdata <= '0;
      memread_o <= 1'b0;
      memwrite_o <= 1'b0;
      memaddr_o <= '0;
      memwdata_o <= '0;
      resp_valid_o <= 1'b0;
      resp_err_o <= 1'b0;
      resp_rdata_o <= '0;
    end else begin
      memread_o <= 1'b0;
      memwrite_o <= 1'b0;
      resp_valid_o <= 1'b0;
      resp_err_o <= 1'b0;
      case (r_state)
        IDLE: if (req_valid_i) begin
          r_size <= req_size_i;
          r_a <= req_addr_i[1:0];
          r_uns <= req_unsigned_i;
          r_wdata <= req_wdata_i;
          memaddr_o <= {req_addr_i[AW-1:2], 2'b00};
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
          if (misaligned(req_size_i, req_addr_i[1:0])) begin
            r_state <= RESP;
            resp_valid_o <= 1'b1;
            resp_err_o <= 1'b1;
            resp_rdata_o <= '0;
          end else
`endif
          if (!req_we_i) begin
            r_state <= LD_ISSUE;
            memread_o <= 1'b1;
          end else if (req_size_i == SIZE_B || req_size_i == SIZE_H) begin
            r_state <= RMW_ISSUE;
            memread_o <= 1'b1;
          end else begin
            r_state <= ST_WRITE;
            memwrite_o <= 1'b1;
            memwdata_o <= req_wdata_i;
          end
        end
        LD_ISSUE: r_state <= LD_DATA;
        LD_DATA: begin
          r_state <= RESP;
          resp_valid_o <= 1'b1;
          resp_rdata_o <= w_load;
        end
        RMW_ISSUE: r_state <= RMW_MERGE;
        RMW_MERGE: begin
          r_state <= ST_WRITE;
          memwrite_o <= 1'b1;
          memwdata_o <= w_merged;
        end
        ST_WRITE: begin
          r_state <= RESP;
          resp_valid_o <= 1'b1;
          resp_rdata_o <= '0;
        end
        RESP: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and randomized checks of mem_access_unit against a byte-level memory model.
module tb_mem_access_unit;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid_i = 1'b0, req_we_i = 1'b0, req_unsigned_i = 1'b0;
  logic [1:0] req_size_i = 2'b00;
  logic [31:0] req_addr_i = '0, req_wdata_i = '0, memrdata_i = '0;
  logic req_ready_o, resp_valid_o, resp_err_o, memread_o, memwrite_o;
  logic [31:0] resp_rdata_o, memaddr_o, memwdata_o;

  mem_access_unit dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_we_i(req_we_i), .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .resp_valid_o(resp_valid_o),
    .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o), .memread_o(memread_o),
    .memwrite_o(memwrite_o), .memaddr_o(memaddr_o), .memwdata_o(memwdata_o),
    .memrdata_i(memrdata_i)
  );

  always #5 clk = ~clk;

  // Responder: 64 words at 0x1000..0x10FF, one-cycle read latency.
  logic [31:0] mem [0:63];
  always @(posedge clk) begin
    if (memwrite_o) mem[memaddr_o[7:2]] <= memwdata_o;
    if (memread_o) memrdata_i <= mem[memaddr_o[7:2]];
  end

  // Reference model: byte-addressed view of the same region.
  logic [7:0] rb [0:255];
  int n_checks = 0, n_pass = 0;
  int o_lat, o_nr, o_nw, o_rcyc, o_wcyc, o_both;
  logic [31:0] o_rdata, o_raddr, o_waddr, o_wdata;
  logic o_err;

  task automatic set_word(input int idx, input logic [31:0] v);
    mem[idx] = v;
    for (int i = 0; i < 4; i++) rb[4*idx+i] = v[8*i +: 8];
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit model_mis(input logic [1:0] sz, input logic [31:0] addr);
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
    return (addr % nbytes(sz)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] sz, input logic uns);
    int n = nbytes(sz);
    longint base = addr - (addr % n);
    longint v = 0;
    for (int i = 0; i < n; i++) v += longint'(rb[(base + i) & 255]) << (8*i);
    if (!uns && n < 4 && v >= (longint'(1) << (8*n - 1))) v -= longint'(1) << (8*n);
    return 32'(v);
  endfunction

  task automatic model_store(input logic [31:0] addr, input logic [1:0] sz, input logic [31:0] wd);
    int n = nbytes(sz);
    longint base = addr - (addr % n);
    for (int i = 0; i < n; i++) rb[(base + i) & 255] = 8'(wd >> (8*i));
  endtask

  task automatic run_op(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd, input bit hold);
    o_lat = -1; o_nr = 0; o_nw = 0; o_rcyc = -1; o_wcyc = -1; o_both = 0;
    o_rdata = 'x; o_err = 1'bx; o_raddr = 'x; o_waddr = 'x; o_wdata = 'x;
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = we; req_size_i = sz; req_unsigned_i = uns;
    req_addr_i = addr; req_wdata_i = wd;
    for (int i = 0; i < 20 && !req_ready_o; i++) @(negedge clk);
    @(posedge clk);
    if (!hold) #1 req_valid_i = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (memread_o) begin o_nr++; if (o_rcyc < 0) begin o_rcyc = k; o_raddr = memaddr_o; end end
      if (memwrite_o) begin o_nw++; if (o_wcyc < 0) begin o_wcyc = k; o_waddr = memaddr_o; o_wdata = memwdata_o; end end
      if (memread_o && memwrite_o) o_both++;
      if (resp_valid_o) begin o_lat = k; o_rdata = resp_rdata_o; o_err = resp_err_o; break; end
    end
    req_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_checks++; if (req_ready_o !== 1'b1) $display("FAIL rst_ready: got %b want 1", req_ready_o); else n_pass++;
    n_checks++; if (resp_valid_o !== 1'b0) $display("FAIL rst_resp_valid: got %b want 0", resp_valid_o); else n_pass++;
    n_checks++; if (resp_err_o !== 1'b0) $display("FAIL rst_err: got %b want 0", resp_err_o); else n_pass++;
    n_checks++; if ({memread_o, memwrite_o} !== 2'b00) $display("FAIL rst_strobes: got %b want 00", {memread_o, memwrite_o}); else n_pass++;
    n_checks++; if (memaddr_o !== 32'h0) $display("FAIL rst_memaddr: got %h want 0", memaddr_o); else n_pass++;
    n_checks++; if (memwdata_o !== 32'h0) $display("FAIL rst_memwdata: got %h want 0", memwdata_o); else n_pass++;
    n_checks++; if (resp_rdata_o !== 32'h0) $display("FAIL rst_rdata: got %h want 0", resp_rdata_o); else n_pass++;
  endtask

  task automatic test_loads();
    logic [1:0] szs [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
    logic       uns [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] adr [4] = '{32'h1005, 32'h1005, 32'h1006, 32'h1006};
    logic [31:0] exp [4] = '{32'hFFFF_FFF0, 32'h0000_00F0, 32'hFFFF_8077, 32'h0000_8077};
    for (int t = 0; t < 4; t++) begin
      run_op(1'b0, szs[t], uns[t], adr[t], 32'h0, 1'b0);
      n_checks++; if (o_rdata !== exp[t] || o_lat != 3) $display("FAIL load%0d: got %h@%0d want %h@3", t, o_rdata, o_lat, exp[t]); else n_pass++;
      n_checks++; if (o_nr != 1 || o_nw != 0 || o_raddr !== 32'h1004) $display("FAIL load%0d_bus: reads %0d writes %0d addr %h want 1 0 00001004", t, o_nr, o_nw, o_raddr); else n_pass++;
    end
  endtask

  task automatic test_sub_store();
    run_op(1'b1, 2'b00, 1'b0, 32'h1006, 32'h0000_0012, 1'b0);
    model_store(32'h1006, 2'b00, 32'h12);
    n_checks++; if (o_rcyc != 1 || o_nr != 1) $display("FAIL sb_read: cycle %0d count %0d want 1 1", o_rcyc, o_nr); else n_pass++;
    n_checks++; if (o_wcyc != 3 || o_wdata !== 32'h8012_F0A5) $display("FAIL sb_write: cycle %0d data %h want 3 8012f0a5", o_wcyc, o_wdata); else n_pass++;
    n_checks++; if (o_lat != 4 || o_rdata !== 32'h0) $display("FAIL sb_resp: cycle %0d rdata %h want 4 0", o_lat, o_rdata); else n_pass++;
    @(negedge clk);
    n_checks++; if (mem[1] !== 32'h8012_F0A5) $display("FAIL sb_mem: got %h want 8012f0a5", mem[1]); else n_pass++;
    set_word(1, 32'h8077_F0A5);
  endtask

  task automatic test_back_to_back();
    run_op(1'b1, 2'b10, 1'b0, 32'h1008, 32'hDEAD_BEEF, 1'b1);
    model_store(32'h1008, 2'b10, 32'hDEAD_BEEF);
    n_checks++; if (o_wcyc != 1 || o_nr != 0 || o_wdata !== 32'hDEAD_BEEF) $display("FAIL sw_bus: wcyc %0d reads %0d data %h want 1 0 deadbeef", o_wcyc, o_nr, o_wdata); else n_pass++;
    n_checks++; if (o_lat != 2 || o_nw != 1) $display("FAIL sw_resp: cycle %0d writes %0d want 2 1", o_lat, o_nw); else n_pass++;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_checks++; if (req_ready_o !== 1'b1 || memwrite_o !== 1'b0 || memread_o !== 1'b0) $display("FAIL sw_no_reaccept%0d: ready %b wr %b rd %b want 1 0 0", k, req_ready_o, memwrite_o, memread_o); else n_pass++;
    end
    run_op(1'b0, 2'b10, 1'b0, 32'h1008, 32'h0, 1'b0);
    n_checks++; if (o_rdata !== 32'hDEAD_BEEF || o_lat != 3) $display("FAIL lw_after_sw: got %h@%0d want deadbeef@3", o_rdata, o_lat); else n_pass++;
  endtask

  task automatic test_misalign();
    run_op(1'b0, 2'b10, 1'b0, 32'h1002, 32'h0, 1'b0);
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
    n_checks++; if (o_err !== 1'b1 || o_lat != 1 || o_rdata !== 32'h0) $display("FAIL lw_misalign: err %b cycle %0d rdata %h want 1 1 0", o_err, o_lat, o_rdata); else n_pass++;
    n_checks++; if (o_nr != 0 || o_nw != 0) $display("FAIL lw_misalign_strobes: reads %0d writes %0d want 0 0", o_nr, o_nw); else n_pass++;
`else
    n_checks++; if (o_raddr !== 32'h1000 || o_err !== 1'b0) $display("FAIL lw_unaligned: addr %h err %b want 00001000 0", o_raddr, o_err); else n_pass++;
    n_checks++; if (o_rdata !== model_load(32'h1000, 2'b10, 1'b0)) $display("FAIL lw_unaligned_data: got %h want %h", o_rdata, model_load(32'h1000, 2'b10, 1'b0)); else n_pass++;
`endif
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = 1'b1; req_size_i = 2'b00; req_unsigned_i = 1'b0;
    req_addr_i = 32'h1006; req_wdata_i = 32'h12;
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (req_ready_o !== 1'b1 || memwrite_o !== 1'b0 || resp_valid_o !== 1'b0) $display("FAIL midrst_state: ready %b wr %b valid %b want 1 0 0", req_ready_o, memwrite_o, resp_valid_o); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (memwrite_o || resp_valid_o) bad++;
    end
    n_checks++; if (bad != 0) $display("FAIL midrst_quiet: got %0d stray cycles want 0", bad); else n_pass++;
    n_checks++; if (mem[1] !== 32'h8077_F0A5) $display("FAIL midrst_mem: got %h want 8077f0a5", mem[1]); else n_pass++;
  endtask

  task automatic test_random();
    int errs = 0, both = 0, mem_bad = 0;
    for (int t = 0; t < 200; t++) begin
      logic we = 1'($urandom_range(0, 1));
      logic [1:0] sz = 2'($urandom_range(0, 3));
      logic uns = 1'($urandom_range(0, 1));
      logic [31:0] addr = 32'h1000 + $urandom_range(0, 255);
      logic [31:0] wd = $urandom;
      bit mis = model_mis(sz, addr);
      int exp_lat = mis ? 1 : !we ? 3 : (nbytes(sz) == 4) ? 2 : 4;
      logic [31:0] exp_rd = (mis || we) ? 32'h0 : model_load(addr, sz, uns);
      run_op(we, sz, uns, addr, wd, 1'b0);
      if (we && !mis) model_store(addr, sz, wd);
      both += o_both;
      n_checks++;
      if (o_lat != exp_lat || o_rdata !== exp_rd || o_err !== logic'(mis)) begin
        errs++;
        $display("FAIL rand%0d we=%b sz=%0d addr=%h: rdata %h lat %0d err %b want %h %0d %b", t, we, sz, addr, o_rdata, o_lat, o_err, exp_rd, exp_lat, mis);
      end else n_pass++;
    end
    n_checks++; if (both != 0) $display("FAIL rand_strobe_overlap: got %0d want 0", both); else n_pass++;
    @(negedge clk);
    for (int w = 0; w < 64; w++)
      if (mem[w] !== {rb[4*w+3], rb[4*w+2], rb[4*w+1], rb[4*w]}) mem_bad++;
    n_checks++; if (mem_bad != 0) $display("FAIL rand_mem_image: got %0d differing words want 0", mem_bad); else n_pass++;
  endtask

  initial begin
    for (int w = 0; w < 64; w++) set_word(w, $urandom);
    set_word(1, 32'h8077_F0A5);
    test_reset();
    test_loads();
    test_sub_store();
    test_back_to_back();
    test_misalign();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
